// File: rtl/psu_maskext_seq_if.sv
// Handshake and data bundle between the PSU mask-extension engine and its
// neighbours: batch input side, result output side, abort and status.
interface psu_maskext_seq_if #(
   parameter int NUM_PCU    = 2,
   parameter int PCHADDR_BW = 2,
   parameter int NUM_PCUQB  = 16,
   parameter int NUM_PQ     = 64
);
   logic                            in_valid;
   logic                            in_ready;
   logic                            merge_mode;
   logic [NUM_PCU*PCHADDR_BW-1:0]   pchidx_list;
   logic [NUM_PCU-1:0]              pivalid_list;
   logic [NUM_PCU*NUM_PCUQB-1:0]    mask_array;
   logic [NUM_PCU*NUM_PCUQB-1:0]    special_array;
   logic                            flush;
   logic                            out_valid;
   logic                            out_ready;
   logic                            busy;
   logic [NUM_PQ-1:0]               mask_ext_array;
   logic [NUM_PQ-1:0]               special_ext_array;
   logic                            conflict_err;
   logic                            range_err;

   // Upstream/downstream side: drives batches, abort and result acceptance.
   modport master (
      output in_valid, merge_mode, pchidx_list, pivalid_list, mask_array,
             special_array, flush, out_ready,
      input  in_ready, out_valid, busy, mask_ext_array, special_ext_array,
             conflict_err, range_err
   );

   // Engine side.
   modport slave (
      input  in_valid, merge_mode, pchidx_list, pivalid_list, mask_array,
             special_array, flush, out_ready,
      output in_ready, out_valid, busy, mask_ext_array, special_ext_array,
             conflict_err, range_err
   );
endinterface

// File: rtl/psu_maskext_seq.sv
// PSU mask-extension engine. A batch of per-PCU mask/special vectors is
// scattered into per-patch buffers at accept, then swept into the
// physical-qubit-wide output arrays one UCC x QBCTRL slice per cycle.
// The result is held until the downstream stage takes it.
module psu_maskext_seq #(
   parameter int NUM_PCU    = 2,
   parameter int NUM_PCH    = 4,
   parameter int PCHADDR_BW = 2,
   parameter int NUM_UC     = 4,
   parameter int NUM_QB     = 4,
   parameter int NUM_UCC    = 2,
   parameter int NUM_QBCTRL = 2
) (
   input logic               clk,
   input logic               rst,
   psu_maskext_seq_if.slave  bus
);
   localparam int NUM_PCUQB = NUM_UC * NUM_QB;
   localparam int NUM_PQ    = NUM_PCH * NUM_PCUQB;
   localparam int UC_STEPS  = NUM_UC / NUM_UCC;
   localparam int QB_STEPS  = NUM_QB / NUM_QBCTRL;
   localparam int S         = UC_STEPS * QB_STEPS;
   localparam int STEP_BW   = (S > 1) ? $clog2(S) : 1;
   localparam logic [STEP_BW-1:0] LAST_STEP = STEP_BW'(S - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SWEEP = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   logic [1:0]            state;
   logic [STEP_BW-1:0]    step;
   logic                  merge_q;
   logic [NUM_PCUQB-1:0]  pch_mask    [NUM_PCH];
   logic [NUM_PCUQB-1:0]  pch_special [NUM_PCH];
   logic [NUM_PQ-1:0]     mask_ext_q;
   logic [NUM_PQ-1:0]     special_ext_q;
   logic                  conflict_q;
   logic                  range_q;

   // Accept-time scatter results
   logic [NUM_PCUQB-1:0]  scat_mask    [NUM_PCH];
   logic [NUM_PCUQB-1:0]  scat_special [NUM_PCH];
   logic [NUM_PCH-1:0]    scat_hit;
   logic                  scat_conflict;
   logic                  scat_range;
   logic [PCHADDR_BW-1:0] cur_idx;

   // Sweep-time next values of the ext arrays
   logic [NUM_PQ-1:0]     sweep_mask;
   logic [NUM_PQ-1:0]     sweep_special;
   int                    ucsel;
   int                    qbsel;

   assign bus.in_ready          = (state == ST_IDLE);
   assign bus.busy              = (state == ST_SWEEP);
   assign bus.out_valid         = (state == ST_DONE);
   assign bus.mask_ext_array    = mask_ext_q;
   assign bus.special_ext_array = special_ext_q;
   assign bus.conflict_err      = conflict_q;
   assign bus.range_err         = range_q;

   // Scatter every valid in-range PCU into its patch; later PCUs overwrite earlier ones.
   always_comb begin
      // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
      for (int p = 0; p < NUM_PCH; p++) begin
         scat_mask[p]    = '0;
         scat_special[p] = '0;
      end
      scat_hit      = '0;
      scat_conflict = 1'b0;
      scat_range    = 1'b0;
      cur_idx       = '0;
      for (int i = 0; i < NUM_PCU; i++) begin
         if (bus.pivalid_list[i]) begin
            cur_idx = bus.pchidx_list[i*PCHADDR_BW +: PCHADDR_BW];
            if (int'(cur_idx) >= NUM_PCH) scat_range = 1'b1;
            for (int p = 0; p < NUM_PCH; p++) begin
               if (cur_idx == PCHADDR_BW'(p)) begin
                  if (scat_hit[p]) scat_conflict = 1'b1;
                  scat_hit[p]     = 1'b1;
                  scat_mask[p]    = bus.mask_array[i*NUM_PCUQB +: NUM_PCUQB];
                  scat_special[p] = bus.special_array[i*NUM_PCUQB +: NUM_PCUQB];
               end
            end
         end
      end
   end

   // Update the slice selected by the current step (ucsel, qbsel); other bits keep their value.
   always_comb begin
      sweep_mask    = mask_ext_q;
      sweep_special = special_ext_q;
      ucsel         = int'(step) / QB_STEPS;
      qbsel         = int'(step) % QB_STEPS;
      for (int p = 0; p < NUM_PCH; p++) begin
         for (int j = 0; j < NUM_UC; j++) begin
            for (int q = 0; q < NUM_QB; q++) begin
               if ((j / NUM_UCC == ucsel) && (q / NUM_QBCTRL == qbsel)) begin
                  sweep_mask[p*NUM_PCUQB + j*NUM_QB + q] =
                     pch_mask[p][j*NUM_QB + q] |
                     (merge_q & mask_ext_q[p*NUM_PCUQB + j*NUM_QB + q]);
                  sweep_special[p*NUM_PCUQB + j*NUM_QB + q] =
                     pch_special[p][j*NUM_QB + q] |
                     (merge_q & special_ext_q[p*NUM_PCUQB + j*NUM_QB + q]);
               end
            end
         end
      end
   end

   // Control FSM and all datapath registers; flush overrides every transition.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (rst) begin
         state         <= ST_IDLE;
         step          <= '0;
         merge_q       <= 1'b0;
         mask_ext_q    <= '0;
         special_ext_q <= '0;
         conflict_q    <= 1'b0;
         range_q       <= 1'b0;
         // NOTE: the patch buffers are small flop arrays, not RAM, so they take the reset too.
         for (int p = 0; p < NUM_PCH; p++) begin
            pch_mask[p]    <= '0;
            pch_special[p] <= '0;
         end
      end else if (bus.flush) begin
         state         <= ST_IDLE;
         step          <= '0;
         merge_q       <= 1'b0;
         mask_ext_q    <= '0;
         special_ext_q <= '0;
         conflict_q    <= 1'b0;
         range_q       <= 1'b0;
         for (int p = 0; p < NUM_PCH; p++) begin
            pch_mask[p]    <= '0;
            pch_special[p] <= '0;
         end
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  for (int p = 0; p < NUM_PCH; p++) begin
                     pch_mask[p]    <= scat_mask[p];
                     pch_special[p] <= scat_special[p];
                  end
                  conflict_q <= scat_conflict;
                  range_q    <= scat_range;
                  merge_q    <= bus.merge_mode;
                  if (!bus.merge_mode) begin
                     mask_ext_q    <= '0;
                     special_ext_q <= '0;
                  end
                  step  <= '0;
                  state <= ST_SWEEP;
               end
            end
            ST_SWEEP: begin
               mask_ext_q    <= sweep_mask;
               special_ext_q <= sweep_special;
               if (step == LAST_STEP) begin
                  step  <= '0;
                  state <= ST_DONE;
               end else begin
                  step <= step + STEP_BW'(1);
               end
            end
            ST_DONE: begin
               if (bus.out_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_psu_maskext_seq.sv
// Directed bench for psu_maskext_seq: a table of batches with hand-computed
// extended arrays, followed by backpressure, reset-abort and flush-abort
// sequences. PCHADDR_BW is 3 so out-of-range patch indices can be driven.
module tb_psu_maskext_seq;
   localparam int NUM_PCU    = 2;
   localparam int NUM_PCH    = 4;
   localparam int PCHADDR_BW = 3;
   localparam int NUM_PCUQB  = 16;
   localparam int NUM_PQ     = 64;
   localparam int S          = 4;
   localparam int BOUND      = 20;

   typedef struct {
      logic [1:0]  pv;
      logic [2:0]  idx0;
      logic [2:0]  idx1;
      logic [15:0] m0;
      logic [15:0] m1;
      logic [15:0] s0;
      logic [15:0] s1;
      logic        merge;
      logic [63:0] exp_mask;
      logic [63:0] exp_spec;
      logic        exp_conf;
      logic        exp_range;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;
   vec_t vecs [9];

   psu_maskext_seq_if #(
      .NUM_PCU(NUM_PCU), .PCHADDR_BW(PCHADDR_BW),
      .NUM_PCUQB(NUM_PCUQB), .NUM_PQ(NUM_PQ)
   ) bus ();

   psu_maskext_seq #(
      .NUM_PCU(NUM_PCU), .NUM_PCH(NUM_PCH), .PCHADDR_BW(PCHADDR_BW),
      .NUM_UC(4), .NUM_QB(4), .NUM_UCC(2), .NUM_QBCTRL(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Wait (bounded) for in_ready, then present one batch for exactly one accept edge.
   task automatic accept_vec(input vec_t v, input string tag);
      int cyc;
      cyc = 0;
      @(negedge clk);
      while (!bus.in_ready && cyc < BOUND) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
      bus.pivalid_list  = v.pv;
      bus.pchidx_list   = {v.idx1, v.idx0};
      bus.mask_array    = {v.m1, v.m0};
      bus.special_array = {v.s1, v.s0};
      bus.merge_mode    = v.merge;
      bus.in_valid      = 1'b1;
      @(posedge clk);
      #1;
      // Scramble the inputs: they must be ignored once the batch is accepted.
      bus.in_valid      = 1'b0;
      bus.pivalid_list  = 2'b11;
      bus.pchidx_list   = {3'd0, 3'd0};
      bus.mask_array    = '1;
      bus.special_array = '1;
      bus.merge_mode    = ~v.merge;
   endtask

   // Count cycles until out_valid (bounded); returns latency in edges and busy cycles.
   task automatic wait_done(output int lat, output int bcnt);
      int  cyc;
      bit  done;
      cyc  = 0;
      bcnt = 0;
      done = 1'b0;
      while (!done && cyc < BOUND) begin
         @(negedge clk);
         cyc++;
         if (bus.busy) bcnt++;
         if (bus.out_valid) done = 1'b1;
      end
      lat = done ? cyc - 1 : -1;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int lat, bcnt;
      accept_vec(v, tag);
      wait_done(lat, bcnt);
      check({tag, "_latency"}, 64'(lat), 64'(S));
      check({tag, "_busy_cycles"}, 64'(bcnt), 64'(S));
      check({tag, "_mask"}, bus.mask_ext_array, v.exp_mask);
      check({tag, "_special"}, bus.special_ext_array, v.exp_spec);
      check({tag, "_conflict"}, 64'(bus.conflict_err), 64'(v.exp_conf));
      check({tag, "_range"}, 64'(bus.range_err), 64'(v.exp_range));
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      check({tag, "_retire_ready"}, {62'd0, bus.in_ready, bus.out_valid}, 64'b10);
      check({tag, "_held_mask"}, bus.mask_ext_array, v.exp_mask);
   endtask

   initial begin
      int   lat, bcnt;
      vec_t v;

      //          pv     idx0  idx1  m0        m1        s0        s1        mg    exp_mask                 exp_spec                 cf    rg
      vecs[0] = '{2'b01, 3'd2, 3'd3, 16'hA5C3, 16'hFFFF, 16'h1234, 16'hFFFF, 1'b0, 64'h0000_A5C3_0000_0000, 64'h0000_1234_0000_0000, 1'b0, 1'b0};
      vecs[1] = '{2'b11, 3'd1, 3'd1, 16'h00FF, 16'hFF00, 16'hAAAA, 16'h5555, 1'b0, 64'h0000_0000_FF00_0000, 64'h0000_0000_5555_0000, 1'b1, 1'b0};
      vecs[2] = '{2'b01, 3'd5, 3'd0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 64'h0,                    64'h0,                    1'b0, 1'b1};
      vecs[3] = '{2'b01, 3'd0, 3'd2, 16'h000F, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 64'h0000_0000_0000_000F, 64'h0000_0000_0000_0001, 1'b0, 1'b0};
      vecs[4] = '{2'b01, 3'd0, 3'd2, 16'hF000, 16'hFFFF, 16'h0010, 16'hFFFF, 1'b1, 64'h0000_0000_0000_F00F, 64'h0000_0000_0000_0011, 1'b0, 1'b0};
      vecs[5] = '{2'b11, 3'd3, 3'd0, 16'h1111, 16'h2222, 16'h8001, 16'h0180, 1'b0, 64'h1111_0000_0000_2222, 64'h8001_0000_0000_0180, 1'b0, 1'b0};
      vecs[6] = '{2'b10, 3'd1, 3'd6, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 64'h1111_0000_0000_2222, 64'h8001_0000_0000_0180, 1'b0, 1'b1};
      vecs[7] = '{2'b11, 3'd7, 3'd2, 16'hFFFF, 16'hBEEF, 16'hFFFF, 16'h0042, 1'b0, 64'h0000_BEEF_0000_0000, 64'h0000_0042_0000_0000, 1'b0, 1'b1};
      vecs[8] = '{2'b11, 3'd3, 3'd3, 16'h0F0F, 16'h3000, 16'h0000, 16'hC000, 1'b1, 64'h3000_BEEF_0000_0000, 64'hC000_0042_0000_0000, 1'b1, 1'b0};

      bus.in_valid      = 1'b0;
      bus.merge_mode    = 1'b0;
      bus.pchidx_list   = '0;
      bus.pivalid_list  = '0;
      bus.mask_array    = '0;
      bus.special_array = '0;
      bus.flush         = 1'b0;
      bus.out_ready     = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_ctrl", {60'd0, bus.in_ready, bus.out_valid, bus.busy, 1'b0}, 64'b1000);
      check("reset_mask", bus.mask_ext_array, 64'h0);
      check("reset_special", bus.special_ext_array, 64'h0);
      check("reset_errs", {62'd0, bus.conflict_err, bus.range_err}, 64'h0);

      // Table of batches
      for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("v%0d", i));

      // Backpressure: result and handshake must hold while out_ready stays low
      v = vecs[0];
      v.idx0 = 3'd1; v.m0 = 16'h1234; v.s0 = 16'h4321;
      accept_vec(v, "bp");
      wait_done(lat, bcnt);
      check("bp_latency", 64'(lat), 64'(S));
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check($sformatf("bp_hold_ctrl%0d", c), {62'd0, bus.out_valid, bus.in_ready}, 64'b10);
         check($sformatf("bp_hold_mask%0d", c), bus.mask_ext_array, 64'h0000_0000_1234_0000);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      check("bp_release_ctrl", {62'd0, bus.out_valid, bus.in_ready}, 64'b01);
      check("bp_release_special", bus.special_ext_array, 64'h0000_0000_4321_0000);

      // Asynchronous reset at sweep step 2
      accept_vec(vecs[0], "rst_abort");
      repeat (3) @(negedge clk);
      check("rst_abort_busy", 64'(bus.busy), 64'd1);
      check("rst_abort_partial", bus.mask_ext_array, 64'h0000_00C3_0000_0000);
      rst = 1'b1;
      #1;
      check("rst_abort_ctrl", {62'd0, bus.out_valid, bus.busy}, 64'h0);
      check("rst_abort_mask", bus.mask_ext_array, 64'h0);
      check("rst_abort_special", bus.special_ext_array, 64'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_abort_ready", 64'(bus.in_ready), 64'd1);

      // Synchronous flush at sweep step 2 (conflicting batch so the flag is set)
      v = vecs[0];
      v.pv = 2'b11; v.idx1 = 3'd2; v.m1 = 16'hA5C3; v.m0 = 16'h00FF;
      accept_vec(v, "flush");
      repeat (3) @(negedge clk);
      check("flush_partial", bus.mask_ext_array, 64'h0000_00C3_0000_0000);
      check("flush_conflict_pre", 64'(bus.conflict_err), 64'd1);
      bus.flush = 1'b1;
      #1;
      check("flush_before_edge", bus.mask_ext_array, 64'h0000_00C3_0000_0000);
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      check("flush_mask", bus.mask_ext_array, 64'h0);
      check("flush_special", bus.special_ext_array, 64'h0);
      check("flush_ctrl", {60'd0, bus.in_ready, bus.out_valid, bus.busy, bus.conflict_err}, 64'b1000);

      // Normal operation resumes after the aborts
      run_vec(vecs[1], "post_abort");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
